// File: rtl/player_payout_credit.sv
// player_payout_credit
//
// This is the sequential payout engine. After a spin resolves it credits
// bet x multiplier coins into the 17-bit player score. Coins are credited
// one at a time, one every COIN_DIV clocks, so the display and sound logic
// can animate each one. The score saturates at MAX_SCORE.
//
// Optional feature macro: PLAYER_PAYOUT_INSTANT_EN
//   defined   : the whole payout is credited in one PAY cycle, clipped at
//               MAX_SCORE, followed by a single coin pulse. done follows
//               one cycle later.
//   undefined : coins are credited one by one at the COIN_DIV cadence.
//
// Parameters
//   COIN_DIV   clocks per credited coin (>= 1)
//   MAX_BET    coins per max bet (<= 15); a single bet is 1 coin
//   MAX_SCORE  score saturation ceiling
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   start       payout request, sampled only in IDLE
//   maxbet      1: bet = MAX_BET, 0: bet = 1
//   multiplier  payout multiplier 0..15
//   ogScore     score latched on an accepted start
//   newScore    running credited score (registered)
//   busy        high whenever the engine is not IDLE
//   coin        one-cycle pulse per credited coin
//   done        one-cycle pulse when the payout completes
//   saturated   sticky: a credit was clipped at MAX_SCORE
module player_payout_credit #(
   parameter int unsigned COIN_DIV  = 4,
   parameter int unsigned MAX_BET   = 5,
   parameter logic [16:0] MAX_SCORE = 17'd99999
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        maxbet,
   input  logic [3:0]  multiplier,
   input  logic [16:0] ogScore,
   output logic [16:0] newScore,
   output logic        busy,
   output logic        coin,
   output logic        done,
   output logic        saturated
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PAY  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [16:0] score;
   logic [7:0]  remaining;
   logic [3:0]  bet;
   logic [7:0]  payout;

   always_comb begin
      bet    = maxbet ? 4'(MAX_BET) : 4'd1;
      payout = {4'd0, bet} * {4'd0, multiplier};
   end

`ifdef PLAYER_PAYOUT_INSTANT_EN
   logic [17:0] sum_all;
   logic        clip;

   always_comb begin
      sum_all = {1'b0, score} + {10'd0, remaining};
      clip    = sum_all > {1'b0, MAX_SCORE};
   end
`else
   localparam int unsigned          DIV_W      = (COIN_DIV > 1) ? $clog2(COIN_DIV) : 1;
   localparam logic [DIV_W-1:0]     DIV_RELOAD = DIV_W'(COIN_DIV - 1);

   logic [DIV_W-1:0] divider;
   logic [17:0]      sum_one;
   logic             credit_ok;

   // The increment is formed at 18 bits so a score already at or above
   // MAX_SCORE can never wrap.
   always_comb begin
      sum_one   = {1'b0, score} + 18'd1;
      credit_ok = sum_one <= {1'b0, MAX_SCORE};
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         score     <= '0;
         remaining <= '0;
         coin      <= 1'b0;
         done      <= 1'b0;
         saturated <= 1'b0;
`ifndef PLAYER_PAYOUT_INSTANT_EN
         divider   <= '0;
`endif
      end else begin
         coin <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  score     <= ogScore;
                  saturated <= 1'b0;
                  remaining <= payout;
`ifndef PLAYER_PAYOUT_INSTANT_EN
                  divider   <= DIV_RELOAD;
`endif
                  if (payout != 8'd0) begin
                     state <= PAY;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            PAY: begin
`ifdef PLAYER_PAYOUT_INSTANT_EN
               coin      <= 1'b1;
               remaining <= '0;
               if (clip) begin
                  score     <= MAX_SCORE;
                  saturated <= 1'b1;
               end else begin
                  score <= sum_all[16:0];
               end
               // done is raised from DONE one cycle later, after the coin.
               state <= DONE;
`else
               if (divider != '0) begin
                  divider <= divider - DIV_W'(1);
               end else begin
                  if (credit_ok) begin
                     score <= sum_one[16:0];
                  end else begin
                     saturated <= 1'b1;
                  end
                  remaining <= remaining - 8'd1;
                  coin      <= 1'b1;
                  divider   <= DIV_RELOAD;
                  if (remaining == 8'd1) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
`endif
            end
            DONE: begin
               // Entering DONE with done already set leaves after one cycle.
               // Otherwise (the instant-credit path) done is raised first.
               if (done) begin
                  state <= IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign newScore = score;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_player_payout_credit.sv
// Testbench for player_payout_credit (default coin-by-coin build).
// Expected coin events are pushed to a scoreboard queue as each payout is
// launched and popped as the DUT pulses coin. All outputs are sampled on the
// falling clock edge. Sample c means c rising edges after E0, the edge that
// accepts start.
module tb_player_payout_credit;

   localparam int unsigned COIN_DIV  = 4;
   localparam int unsigned MAX_BET   = 5;
   localparam logic [16:0] MAX_SCORE = 17'd99999;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        maxbet;
   logic [3:0]  multiplier;
   logic [16:0] ogScore;
   logic [16:0] newScore;
   logic        busy;
   logic        coin;
   logic        done;
   logic        saturated;

   typedef struct {
      int          cyc;
      logic [16:0] score;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   player_payout_credit #(
      .COIN_DIV  (COIN_DIV),
      .MAX_BET   (MAX_BET),
      .MAX_SCORE (MAX_SCORE)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .maxbet     (maxbet),
      .multiplier (multiplier),
      .ogScore    (ogScore),
      .newScore   (newScore),
      .busy       (busy),
      .coin       (coin),
      .done       (done),
      .saturated  (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      resetn = 1'b1; start = 1'b0; maxbet = 1'b0; multiplier = '0; ogScore = '0;
      #1 resetn = 1'b0;
      @(negedge clk);
      total++; if (newScore !== 17'd0) $display("FAIL reset_newScore got %0d exp 0", newScore); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      total++; if (coin !== 1'b0) $display("FAIL reset_coin got %b exp 0", coin); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
      total++; if (saturated !== 1'b0) $display("FAIL reset_sat got %b exp 0", saturated); else passed++;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   // Launch one payout, then follow it sample by sample until one cycle after done.
   task automatic run_payout(input string name, input logic mb, input logic [3:0] mul,
                             input logic [16:0] og, input bit poke);
      int          n;
      int          last;
      int          coins;
      int          dones;
      logic [16:0] m;
      bit          sat_exp;
      exp_t        e;
      n = (mb ? int'(MAX_BET) : 1) * int'(mul);
      last = n * int'(COIN_DIV);
      m = og;
      sat_exp = 1'b0;
      exp_q.delete();
      for (int k = 1; k <= n; k++) begin
         if (m < MAX_SCORE) m = m + 17'd1;
         else sat_exp = 1'b1;
         exp_q.push_back('{cyc: k * int'(COIN_DIV), score: m});
      end
      coins = 0;
      dones = 0;
      @(negedge clk);
      maxbet = mb; multiplier = mul; ogScore = og; start = 1'b1;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            start = 1'b0;
            ogScore = 17'd7;
            total++; if (busy !== 1'b1) $display("FAIL %s busy_rise got %b exp 1", name, busy); else passed++;
            total++; if (saturated !== 1'b0) $display("FAIL %s sat_clear got %b exp 0", name, saturated); else passed++;
            if (n > 0) begin
               total++; if (newScore !== og) $display("FAIL %s latch got %0d exp %0d", name, newScore, og); else passed++;
            end
         end
         if (poke) begin
            if (c == 2) begin start = 1'b1; ogScore = 17'd5; end
            if (c == 3) start = 1'b0;
         end
         if (coin === 1'b1) begin
            coins++;
            if (exp_q.size() == 0) begin
               total++; $display("FAIL %s extra_coin at sample %0d", name, c);
            end else begin
               e = exp_q.pop_front();
               total++; if (c !== e.cyc) $display("FAIL %s coin_time got %0d exp %0d", name, c, e.cyc); else passed++;
               total++; if (newScore !== e.score) $display("FAIL %s coin_score got %0d exp %0d", name, newScore, e.score); else passed++;
            end
         end
         if (done === 1'b1) begin
            dones++;
            total++; if (c !== last) $display("FAIL %s done_time got %0d exp %0d", name, c, last); else passed++;
         end
         if (c == last + 1) begin
            total++; if (busy !== 1'b0) $display("FAIL %s busy_fall got %b exp 0", name, busy); else passed++;
         end
      end
      total++; if (coins !== n) $display("FAIL %s coin_count got %0d exp %0d", name, coins, n); else passed++;
      total++; if (dones !== 1) $display("FAIL %s done_count got %0d exp 1", name, dones); else passed++;
      total++; if (newScore !== m) $display("FAIL %s final_score got %0d exp %0d", name, newScore, m); else passed++;
      total++; if (saturated !== sat_exp) $display("FAIL %s saturated got %b exp %b", name, saturated, sat_exp); else passed++;
      exp_q.delete();
   endtask

   task automatic test_single_bet();   run_payout("single_bet", 1'b0, 4'd3, 17'd100, 1'b0);   endtask
   task automatic test_max_bet();      run_payout("max_bet", 1'b1, 4'd2, 17'd100, 1'b0);      endtask
   task automatic test_zero_payout();  run_payout("zero_payout", 1'b1, 4'd0, 17'd500, 1'b0);  endtask
   task automatic test_saturation();   run_payout("saturation", 1'b1, 4'd1, 17'd99998, 1'b0); endtask
   task automatic test_sat_clear();    run_payout("sat_clear", 1'b0, 4'd2, 17'd40, 1'b0);     endtask
   task automatic test_over_ceiling(); run_payout("over_ceiling", 1'b0, 4'd2, 17'd100500, 1'b0); endtask
   task automatic test_start_ignored(); run_payout("start_ignored", 1'b0, 4'd3, 17'd100, 1'b1); endtask

   // start held high across DONE: the next payout is accepted in the first IDLE cycle.
   task automatic test_back_to_back();
      int   dones;
      exp_t e;
      exp_q.delete();
      exp_q.push_back('{cyc: 4, score: 17'd51});
      exp_q.push_back('{cyc: 10, score: 17'd201});
      dones = 0;
      @(negedge clk);
      maxbet = 1'b0; multiplier = 4'd1; ogScore = 17'd50; start = 1'b1;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         if (c == 0) ogScore = 17'd200;
         if (c == 6) start = 1'b0;
         if (coin === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++; $display("FAIL b2b extra_coin at sample %0d", c);
            end else begin
               e = exp_q.pop_front();
               total++; if (c !== e.cyc) $display("FAIL b2b coin_time got %0d exp %0d", c, e.cyc); else passed++;
               total++; if (newScore !== e.score) $display("FAIL b2b coin_score got %0d exp %0d", newScore, e.score); else passed++;
            end
         end
         if (done === 1'b1) dones++;
         if (c == 5) begin
            total++; if (busy !== 1'b0) $display("FAIL b2b idle_gap got %b exp 0", busy); else passed++;
         end
         if (c == 6) begin
            total++; if (busy !== 1'b1) $display("FAIL b2b restart got %b exp 1", busy); else passed++;
         end
         if (c == 11) begin
            total++; if (busy !== 1'b0) $display("FAIL b2b end_idle got %b exp 0", busy); else passed++;
         end
      end
      total++; if (dones !== 2) $display("FAIL b2b done_count got %0d exp 2", dones); else passed++;
      total++; if (exp_q.size() !== 0) $display("FAIL b2b missing_coins got %0d exp 0", exp_q.size()); else passed++;
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      maxbet = 1'b1; multiplier = 4'd3; ogScore = 17'd1000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      total++; if (newScore !== 17'd1001) $display("FAIL rst_mid pre_score got %0d exp 1001", newScore); else passed++;
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      total++; if (newScore !== 17'd0) $display("FAIL rst_mid newScore got %0d exp 0", newScore); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_mid busy got %b exp 0", busy); else passed++;
      total++; if (coin !== 1'b0) $display("FAIL rst_mid coin got %b exp 0", coin); else passed++;
      total++; if (done !== 1'b0) $display("FAIL rst_mid done got %b exp 0", done); else passed++;
      total++; if (saturated !== 1'b0) $display("FAIL rst_mid sat got %b exp 0", saturated); else passed++;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0 || newScore !== 17'd0) $display("FAIL rst_mid stay_idle busy %b score %0d exp 0 0", busy, newScore); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_bet();
      test_max_bet();
      test_zero_payout();
      test_saturation();
      test_sat_clear();
      test_over_ceiling();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/player_payout_credit.md
# player_payout_credit

Sequential payout engine and the crediting counterpart of the coin-input bet subtractor. After a spin resolves, it takes the bet size and the spin's payout multiplier and credits the winnings back into the 17-bit player score. Crediting runs one coin at a time at a fixed cadence so the display and sound logic can animate each coin. Its registered score output feeds the same score register that the bet subtractor reads.

## Interface
- COIN_DIV, 4: clock cycles per credited coin; must be ≥1.
- MAX_BET, 5: coins per max bet; must be ≤15. A single bet is always 1 coin.
- MAX_SCORE, 17'd99999: score saturation ceiling.

- clk  in  1  single system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a payout; sampled only in IDLE.
- maxbet  in  1  1: bet = MAX_BET; 0: bet = 1.
- multiplier  in  4  payout multiplier from spin result, 0..15.
- ogScore  in  17  current player score; latched on an accepted start.
- newScore  out  17  running credited score (registered).
- busy  out  1  high whenever state ≠ IDLE.
- coin  out  1  one-cycle pulse per credited coin.
- done  out  1  one-cycle pulse when the payout completes.
- saturated  out  1  sticky flag: a credit was clipped at MAX_SCORE.

## Operation
- States: IDLE, PAY, DONE.
- **IDLE**
  - On start=1: latch ogScore into the score register and clear saturated.
  - Load remaining = bet × multiplier (8-bit unsigned, max 225) and load divider = COIN_DIV−1.
  - Go to PAY if remaining ≠ 0, else go to DONE.
- **PAY**, on each clock edge:
  - If divider ≠ 0: decrement divider.
  - Else, credit one coin:
    - If score < MAX_SCORE, score+1; otherwise hold score and set saturated.
    - remaining−1; coin=1 for the next cycle; reload divider.
  - When this credit takes remaining to 0, go to DONE.
- **DONE**: done=1 for exactly one cycle, then go to IDLE.
- Outputs:
  - newScore always equals the score register, so it shows the count increasing.
  - coin still pulses after saturation; only the score is held.
- start while busy is ignored and not queued. If start is still high in the first IDLE cycle after DONE, it starts a new payout.
- Arithmetic: the sum is formed at 18 bits and compared against MAX_SCORE. newScore never exceeds MAX_SCORE and never wraps.
- If ogScore > MAX_SCORE at start, it is latched as-is. Every credit then saturates.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE; newScore=0, busy=0, coin=0, done=0, saturated=0; remaining=0, divider=0.
- Reset mid-payout aborts immediately and discards uncredited coins.
- Let E0 be the edge that accepts start, and N = bet × multiplier.
  - busy rises after E0.
  - Coin k is credited at edge E0 + k·COIN_DIV; coin is high in the following cycle.
  - done is high in the cycle after edge E0 + N·COIN_DIV.
  - The block returns to IDLE at edge E0 + N·COIN_DIV + 1, and busy falls then.
- N = 0: done is high in the cycle after E0; IDLE at E0+1; no coin pulse; newScore = ogScore.
- Maximum latency: 225·COIN_DIV + 1 cycles.

## Configuration
- PLAYER_PAYOUT_INSTANT_EN defined:
  - PAY lasts one cycle and the divider is unused.
  - At edge E0+1: score = min(score + N, MAX_SCORE), and saturated is set if clipped.
  - coin pulses once in the cycle after E0+1; done is high the cycle after that.
  - N = 0 behaves as in the base timing.
- Not defined: the coin-by-coin behaviour above.

## Test plan
- COIN_DIV=4, maxbet=0, multiplier=3, ogScore=100:
  - newScore steps 101 → 102 → 103 at E0+4/8/12, with three coin pulses.
  - done in the cycle after E0+12; busy low from E0+13.
- maxbet=1, multiplier=2, ogScore=100 → 10 coin pulses; final newScore=110; done in the cycle after E0+40.
- multiplier=0, ogScore=500 → no coin; done in the cycle after E0; newScore=500; saturated=0.
- ogScore=99998, maxbet=1, multiplier=1:
  - newScore=99999 after the first coin and holds there.
  - 5 coin pulses; saturated=1 until the next accepted start.
- Mid-payout events:
  - Pulse start during PAY → ignored, with unchanged coin count.
  - Drive resetn=0 mid-PAY → all outputs 0 immediately, state IDLE.
- PLAYER_PAYOUT_INSTANT_EN, maxbet=1, multiplier=4, ogScore=10 → newScore=30 at E0+1; a single coin pulse; done the following cycle.
